// File: rtl/lcd_phrase_sequencer.sv
// lcd_phrase_sequencer: runs the HD44780 4-bit power-on init, then shares the LCD between
// two phrase requesters (round-robin) through a one-request/one-done nibble/byte writer.
module lcd_phrase_sequencer #(
    parameter int unsigned T_POWERUP    = 750000,
    parameter int unsigned T_WAIT_4MS   = 205000,
    parameter int unsigned T_WAIT_100US = 5000,
    parameter int unsigned T_CLEAR      = 82000,
    parameter int unsigned PHRASE_LEN   = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [1:0]              iReq,
    input  logic [8*PHRASE_LEN-1:0] iPhrase0,
    input  logic [8*PHRASE_LEN-1:0] iPhrase1,
    input  logic [1:0]              iLine,
    input  logic                    iWrite_Done,
    output logic [7:0]              oData,
    output logic                    oRS,
    output logic                    oNibble_Only,
    output logic                    oWrite,
    output logic [1:0]              oGrant,
    output logic [1:0]              oDone,
    output logic                    oReady
);

    localparam int unsigned PW    = 8 * PHRASE_LEN;
    localparam int unsigned IDX_W = (PHRASE_LEN > 1) ? $clog2(PHRASE_LEN) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PHRASE_LEN - 1);
    localparam logic [19:0]      CNT_POWERUP = 20'(T_POWERUP - 1);
    localparam logic [19:0]      CNT_4MS     = 20'(T_WAIT_4MS - 1);
    localparam logic [19:0]      CNT_100US   = 20'(T_WAIT_100US - 1);
    localparam logic [19:0]      CNT_CLEAR   = 20'(T_CLEAR - 1);
    localparam logic [2:0]       LAST_STEP   = 3'd7;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_GRANT,
        S_SET_ADDR,
        S_DATA,
        S_FINISH
    } state_t;

    // Init steps 0-3 are the 0x3,0x3,0x3,0x2 wake-up nibbles; 4-7 the configuration bytes.
    function automatic logic [7:0] init_code(input logic [2:0] step);
        case (step)
            3'd0, 3'd1, 3'd2: init_code = 8'h03;
            3'd3:             init_code = 8'h02;
            3'd4:             init_code = 8'h28;
            3'd5:             init_code = 8'h06;
            3'd6:             init_code = 8'h0C;
            default:          init_code = 8'h01;
        endcase
    endfunction

    function automatic logic init_is_nibble(input logic [2:0] step);
        init_is_nibble = (step <= 3'd3);
    endfunction

    function automatic logic init_has_wait(input logic [2:0] step);
        init_has_wait = (step <= 3'd2) || (step == LAST_STEP);
    endfunction

    function automatic logic [19:0] init_wait_cnt(input logic [2:0] step);
        case (step)
            3'd0:       init_wait_cnt = CNT_4MS;
            3'd1, 3'd2: init_wait_cnt = CNT_100US;
            default:    init_wait_cnt = CNT_CLEAR;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [19:0]     cnt_q, cnt_d;
    logic [2:0]      step_q, step_d;
    logic            ptr_q, ptr_d;
    logic            line_q, line_d;
    logic [PW-1:0]   phrase_q, phrase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            nib_q, nib_d;
    logic            write_q, write_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      done_q, done_d;
    logic            ready_q, ready_d;
    logic            pick;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        ptr_d    = ptr_q;
        line_d   = line_q;
        phrase_d = phrase_q;
        idx_d    = idx_q;
        data_d   = data_q;
        rs_d     = rs_q;
        nib_d    = nib_q;
        write_d  = 1'b0;
        grant_d  = grant_q;
        done_d   = 2'b00;
        ready_d  = ready_q;
        pick     = 1'b0;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == CNT_POWERUP) begin
                    state_d = S_INIT_ISSUE;
                    step_d  = 3'd0;
                    data_d  = init_code(3'd0);
                    rs_d    = 1'b0;
                    nib_d   = init_is_nibble(3'd0);
                    write_d = 1'b1;
                end
            end

            S_INIT_ISSUE: begin
                if (iWrite_Done) begin
                    if (init_has_wait(step_q)) begin
                        state_d = S_INIT_WAIT;
                    end else begin
                        step_d  = step_q + 3'd1;
                        data_d  = init_code(step_d);
                        rs_d    = 1'b0;
                        nib_d   = init_is_nibble(step_d);
                        write_d = 1'b1;
                    end
                end
            end

            S_INIT_WAIT: begin
                if (cnt_q == init_wait_cnt(step_q)) begin
                    if (step_q == LAST_STEP) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_INIT_ISSUE;
                        step_d  = step_q + 3'd1;
                        data_d  = init_code(step_d);
                        rs_d    = 1'b0;
                        nib_d   = init_is_nibble(step_d);
                        write_d = 1'b1;
                    end
                end
            end

            // Contention goes to the pointer; the pointer then favours the other requester.
            S_IDLE: begin
                if (iReq != 2'b00) begin
                    pick     = (iReq == 2'b11) ? ptr_q : iReq[1];
                    grant_d  = pick ? 2'b10 : 2'b01;
                    phrase_d = pick ? iPhrase1 : iPhrase0;
                    line_d   = iLine[pick];
                    ptr_d    = ~pick;
                    ready_d  = 1'b0;
                    state_d  = S_GRANT;
                end
            end

            S_GRANT: begin
                state_d = S_SET_ADDR;
                data_d  = line_q ? 8'hC0 : 8'h80;
                rs_d    = 1'b0;
                nib_d   = 1'b0;
                write_d = 1'b1;
            end

            S_SET_ADDR: begin
                if (iWrite_Done) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    data_d  = phrase_q[PW-1 -: 8];
                    rs_d    = 1'b1;
                    nib_d   = 1'b0;
                    write_d = 1'b1;
                end
            end

            S_DATA: begin
                if (iWrite_Done) begin
                    phrase_d = phrase_q << 8;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        done_d  = grant_q;
                        grant_d = 2'b00;
                        state_d = S_FINISH;
                    end else begin
                        data_d  = phrase_d[PW-1 -: 8];
                        write_d = 1'b1;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = S_PWR_WAIT;
            end
        endcase

        // The wait counter restarts on every state change and only runs in wait states.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_PWR_WAIT) || (state_q == S_INIT_WAIT)) begin
            cnt_d = cnt_q + 20'd1;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_PWR_WAIT;
            cnt_q    <= '0;
            step_q   <= '0;
            ptr_q    <= 1'b0;
            line_q   <= 1'b0;
            phrase_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            rs_q     <= 1'b0;
            nib_q    <= 1'b0;
            write_q  <= 1'b0;
            grant_q  <= 2'b00;
            done_q   <= 2'b00;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            ptr_q    <= ptr_d;
            line_q   <= line_d;
            phrase_q <= phrase_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            nib_q    <= nib_d;
            write_q  <= write_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign oData        = data_q;
    assign oRS          = rs_q;
    assign oNibble_Only = nib_q;
    assign oWrite       = write_q;
    assign oGrant       = grant_q;
    assign oDone        = done_q;
    assign oReady       = ready_q;

endmodule

// File: tb/tb_lcd_phrase_sequencer.sv
// Scoreboard bench for lcd_phrase_sequencer: stimulus queues expected writer transfers,
// done pulses and ready rises; a negedge monitor pops and compares them as the DUT emits.
`timescale 1ns/1ps
module tb_lcd_phrase_sequencer;

    localparam int T_PU  = 20;
    localparam int T_4   = 8;
    localparam int T_100 = 4;
    localparam int T_CL  = 6;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  iReq = 2'b00;
    logic [63:0] iPhrase0 = '0;
    logic [63:0] iPhrase1 = '0;
    logic [1:0]  iLine = 2'b00;
    logic        writer_done = 1'b0;
    logic        spurious_done = 1'b0;
    logic        iWrite_Done;
    logic [7:0]  oData;
    logic        oRS, oNibble_Only, oWrite, oReady;
    logic [1:0]  oGrant, oDone;

    assign iWrite_Done = writer_done | spurious_done;

    lcd_phrase_sequencer #(
        .T_POWERUP(T_PU), .T_WAIT_4MS(T_4), .T_WAIT_100US(T_100),
        .T_CLEAR(T_CL), .PHRASE_LEN(8)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iReq(iReq), .iPhrase0(iPhrase0),
        .iPhrase1(iPhrase1), .iLine(iLine), .iWrite_Done(iWrite_Done),
        .oData(oData), .oRS(oRS), .oNibble_Only(oNibble_Only), .oWrite(oWrite),
        .oGrant(oGrant), .oDone(oDone), .oReady(oReady)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        logic       nib;
        int         gap;
        logic [1:0] grant;
    } xfer_t;

    xfer_t      exp_q[$];
    logic [1:0] done_exp_q[$];
    int         ready_exp_q[$];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   last_write_cyc = 0;
    int   last_ready_cyc = 0;
    int   write_count = 0;
    int   done_count = 0;
    logic prev_ready = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] actual);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
    endtask

    always @(posedge Clock) cyc++;

    // Writer model: iWrite_Done is high in the third cycle after the oWrite cycle.
    always begin
        @(negedge Clock);
        if (oWrite && !Reset) begin
            repeat (3) @(posedge Clock);
            #1 writer_done = 1'b1;
            @(posedge Clock);
            #1 writer_done = 1'b0;
        end
    end

    always @(negedge Clock) begin
        xfer_t      e;
        logic [1:0] d;
        int         g;
        if (Reset) begin
            last_write_cyc = cyc + 1;
            prev_ready = 1'b0;
        end else begin
            if (oWrite) begin
                write_count++;
                if (exp_q.size() == 0) begin
                    report_unexpected("unexpected_write", 32'(oData));
                end else begin
                    e = exp_q.pop_front();
                    check_output("write_data", 32'(oData), 32'(e.data));
                    check_output("write_rs", 32'(oRS), 32'(e.rs));
                    check_output("write_nibble", 32'(oNibble_Only), 32'(e.nib));
                    check_output("write_grant", 32'(oGrant), 32'(e.grant));
                    if (e.gap > 0)
                        check_output("write_gap", 32'(cyc - last_write_cyc), 32'(e.gap));
                    else if (e.gap < 0)
                        check_output("grant_latency", 32'(cyc - last_ready_cyc), 32'd2);
                end
                last_write_cyc = cyc;
            end
            if (oDone != 2'b00) begin
                done_count++;
                if (done_exp_q.size() == 0) begin
                    report_unexpected("unexpected_done", 32'(oDone));
                end else begin
                    d = done_exp_q.pop_front();
                    check_output("done_bits", 32'(oDone), 32'(d));
                    check_output("grant_at_done", 32'(oGrant), 32'd0);
                end
            end
            if (oReady && !prev_ready) begin
                if (ready_exp_q.size() == 0) begin
                    report_unexpected("unexpected_ready", 32'(oReady));
                end else begin
                    g = ready_exp_q.pop_front();
                    check_output("ready_gap", 32'(cyc - last_write_cyc), 32'(g));
                end
            end
            if (oReady) last_ready_cyc = cyc;
            prev_ready = oReady;
        end
    end

    task automatic push_init();
        logic [7:0] codes [8];
        int         gaps [8];
        xfer_t      e;
        codes = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h28, 8'h06, 8'h0C, 8'h01};
        gaps  = '{T_PU, T_4 + 4, T_100 + 4, T_100 + 4, 4, 4, 4, 4};
        for (int i = 0; i < 8; i++) begin
            e.data  = codes[i];
            e.rs    = 1'b0;
            e.nib   = (i < 4);
            e.gap   = gaps[i];
            e.grant = 2'b00;
            exp_q.push_back(e);
        end
        ready_exp_q.push_back(T_CL + 4);
    endtask

    task automatic push_phrase(input int who, input logic [63:0] phr, input logic line);
        xfer_t e;
        e.grant = (who == 1) ? 2'b10 : 2'b01;
        e.data  = line ? 8'hC0 : 8'h80;
        e.rs    = 1'b0;
        e.nib   = 1'b0;
        e.gap   = -1;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e.data = phr[63 - 8*i -: 8];
            e.rs   = 1'b1;
            e.gap  = 4;
            exp_q.push_back(e);
        end
        done_exp_q.push_back(e.grant);
        ready_exp_q.push_back(5);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(posedge Clock); #1;
            n++;
        end
        check_output(name, 32'(done_count >= target), 32'd1);
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int n = 0;
        while (write_count < target && n < budget) begin
            @(posedge Clock); #1;
            n++;
        end
        check_output(name, 32'(write_count >= target), 32'd1);
    endtask

    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (!oReady && n < budget) begin
            @(posedge Clock); #1;
            n++;
        end
        check_output(name, 32'(oReady), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_data"}, 32'(oData), 32'd0);
        check_output({tag, "_rs_nib_write"}, 32'({oRS, oNibble_Only, oWrite}), 32'd0);
        check_output({tag, "_grant"}, 32'(oGrant), 32'd0);
        check_output({tag, "_done"}, 32'(oDone), 32'd0);
        check_output({tag, "_ready"}, 32'(oReady), 32'd0);
    endtask

    task automatic apply_stimulus();
        logic [63:0] hola;
        logic [63:0] world;
        logic [63:0] other;
        int base;
        hola  = 64'h484F4C41204D554E;
        world = "WORLD_42";
        other = "abcdefgh";

        // Reset state, then both requesters waiting when IDLE is first reached.
        repeat (3) @(posedge Clock); #1;
        check_all_zero("reset");
        push_init();
        iPhrase0 = hola;
        iPhrase1 = world;
        iLine    = 2'b01;
        iReq     = 2'b11;
        push_phrase(0, hola, 1'b1);
        push_phrase(1, world, 1'b0);
        push_phrase(0, hola, 1'b1);
        push_phrase(1, world, 1'b0);
        Reset = 1'b0;
        wait_done(4, 600, "alternating_done_timeout");
        iReq = 2'b00;

        // Single requester 0 on line 2; its phrase input changes mid-flight.
        repeat (3) @(posedge Clock); #1;
        base = write_count;
        push_phrase(0, hola, 1'b1);
        iReq = 2'b01;
        wait_writes(base + 4, 100, "third_byte_timeout");
        iPhrase0 = "XXXXXXXX";
        iLine    = 2'b00;
        wait_done(5, 100, "single_done_timeout");
        iReq = 2'b00;

        // Reset while the fifth character is in flight.
        repeat (3) @(posedge Clock); #1;
        base = write_count;
        push_phrase(1, world, 1'b0);
        iReq = 2'b10;
        wait_writes(base + 6, 100, "fifth_char_timeout");
        Reset = 1'b1;
        iReq  = 2'b00;
        exp_q.delete();
        done_exp_q.delete();
        ready_exp_q.delete();
        @(posedge Clock); #1;
        check_all_zero("abort");
        push_init();
        repeat (2) @(posedge Clock); #1;
        Reset = 1'b0;

        // Spurious done pulses in the power-up wait and in the 4 ms wait.
        repeat (5) @(posedge Clock); #1;
        spurious_done = 1'b1;
        @(posedge Clock); #1;
        spurious_done = 1'b0;
        repeat (21) @(posedge Clock); #1;
        spurious_done = 1'b1;
        @(posedge Clock); #1;
        spurious_done = 1'b0;
        wait_ready(200, "reinit_ready_timeout");

        // Spurious done pulse in IDLE.
        base = write_count;
        spurious_done = 1'b1;
        @(posedge Clock); #1;
        spurious_done = 1'b0;
        repeat (4) @(posedge Clock); #1;
        check_output("idle_ready_held", 32'(oReady), 32'd1);
        check_output("idle_no_write", 32'(write_count), 32'(base));

        // Pointer restarts at requester 0 after reset.
        base = done_count;
        iPhrase0 = other;
        iLine    = 2'b01;
        iReq     = 2'b11;
        push_phrase(0, other, 1'b1);
        push_phrase(1, world, 1'b0);
        wait_done(base + 2, 300, "post_reset_done_timeout");
        iReq = 2'b00;
        repeat (10) @(posedge Clock); #1;
        check_output("writes_left", 32'(exp_q.size()), 32'd0);
        check_output("dones_left", 32'(done_exp_q.size()), 32'd0);
        check_output("readys_left", 32'(ready_exp_q.size()), 32'd0);
    endtask

    initial begin
        apply_stimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lcd_phrase_sequencer.md
Name: lcd_phrase_sequencer

Overview:
- Owns the Spartan-3E character LCD (4-bit bus, 50 MHz clock).
- Runs the HD44780 power-on init sequence, then shares the display between two requesters using round-robin arbitration.
- For each granted request it sets the DDRAM address and streams an 8-character phrase.
- It drives the downstream nibble/byte LCD writer through a one-request/one-done handshake and never touches the LCD pins directly.

Parameters:
- T_POWERUP, 750000, cycles to wait after reset before the first init nibble (15 ms).
- T_WAIT_4MS, 205000, wait after the first 0x3 nibble (4.1 ms).
- T_WAIT_100US, 5000, wait after the second and third 0x3 nibbles (100 us).
- T_CLEAR, 82000, extra wait after the Clear Display command (1.64 ms).
- PHRASE_LEN, 8, characters per phrase (the phrase bus is 8*PHRASE_LEN bits).

Ports:
- Clock  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high.
- iReq  in  2  level request; bit i belongs to requester i.
- iPhrase0  in  8*PHRASE_LEN  phrase from requester 0; the first character is in bits [8*PHRASE_LEN-1 -: 8].
- iPhrase1  in  8*PHRASE_LEN  phrase from requester 1, same layout.
- iLine  in  2  target line per requester (bit i): 0 = line 1 (addr 0x00), 1 = line 2 (addr 0x40).
- iWrite_Done  in  1  one-cycle pulse from the writer when the current transfer has finished, including its post-write delay.
- oData  out  8  byte to the writer; in nibble mode only [3:0] is used.
- oRS  out  1  register select: 0 = command, 1 = data.
- oNibble_Only  out  1  1 = writer sends oData[3:0] as a single nibble (init only).
- oWrite  out  1  one-cycle request pulse to the writer.
- oGrant  out  2  one-hot; high for the whole phrase service of the granted requester.
- oDone  out  2  one-cycle pulse on bit i when requester i's phrase has completed.
- oReady  out  1  high in IDLE only.

Behaviour:
- Reset values: all outputs 0; state = PWR_WAIT; cycle counter = 0; round-robin pointer = 0 (requester 0 has priority first).
- A Reset asserted in any state, mid-phrase included, aborts the operation. The block returns to PWR_WAIT, no oDone is issued, and the full init sequence reruns.
- Cycle counter: 20 bits. It clears on every state entry and counts while in a WAIT state. A wait of T cycles exits on the cycle the count equals T-1.
- Transfer rule, applied to every nibble and byte:
  - oData, oRS and oNibble_Only are set in the ISSUE state and held stable until iWrite_Done.
  - oWrite is high exactly one cycle, the first cycle of ISSUE.
  - The block then waits in ISSUE for iWrite_Done.
  - iWrite_Done arriving in any other state is ignored.
  - Only one transfer may be outstanding at a time.
- Init sequence:
  - PWR_WAIT(T_POWERUP).
  - Nibble 0x3, then WAIT(T_WAIT_4MS).
  - Nibble 0x3, then WAIT(T_WAIT_100US).
  - Nibble 0x3, then WAIT(T_WAIT_100US).
  - Nibble 0x2.
  - Bytes with RS=0 and oNibble_Only=0: 0x28 (function set), 0x06 (entry mode), 0x0C (display on), 0x01 (clear).
  - WAIT(T_CLEAR), then IDLE.
  - All nibbles are sent with oNibble_Only=1 and RS=0.
- IDLE: oReady=1. iReq is sampled every cycle; requests are level-sensitive and are not latched while not IDLE.
- Arbitration, decided in the IDLE cycle where iReq != 0:
  - If both bits are set, the winner is the requester at the pointer. Otherwise the winner is the single requester.
  - On the next cycle: oGrant[winner]=1, the winner's phrase and line bit are captured into internal registers, and the pointer moves to the other requester.
  - Later changes to iPhrase, iLine or iReq do not affect the phrase in flight.
- Phrase service:
  - SET_ADDR sends command 0x80 for line 1 or 0xC0 for line 2 (RS=0).
  - Then PHRASE_LEN data bytes are sent (RS=1), first character first; the captured register shifts left 8 bits per completed byte.
  - A 3-bit character index (clog2 of PHRASE_LEN) counts completed bytes.
  - After the last iWrite_Done: oDone[winner]=1 for one cycle, oGrant is cleared in the same cycle, and the block goes to IDLE on the next cycle.
  - A requester still holding iReq after oDone can be granted again from IDLE. Fairness comes from the pointer.
- Requester i should deassert iReq on oDone[i]. If iReq is held high, requester i is served repeatedly; when both are held, service alternates 0,1,0,1.
- Latency: from an IDLE cycle with a request to the first oWrite (address command) is 2 cycles.

Test Plan (bench uses T_POWERUP=20, T_WAIT_4MS=8, T_WAIT_100US=4, T_CLEAR=6; writer model returns iWrite_Done 3 cycles after oWrite):
- Reset release -> exact sequence of 4 nibbles (3,3,3,2 with oNibble_Only=1) then bytes 28,06,0C,01; checks that consecutive oWrite pulses are separated by the programmed waits; oReady rises after the clear wait.
- iReq=01, iLine[0]=1, iPhrase0="HOLA MUN" -> oWrite carries C0, then 48 4F 4C 41 20 4D 55 4E with RS=1; oDone=01 once; oGrant=01 throughout.
- iReq=11 in the same IDLE cycle straight after reset -> requester 0 is served first, then requester 1; with both held, four phrases complete in the order 0,1,0,1.
- iPhrase0 changed while the 3rd byte is in flight -> the output bytes still match the phrase captured at grant.
- Reset asserted during the 5th character -> all outputs are 0 the next cycle, no oDone is issued, and the full init sequence replays.
- Spurious iWrite_Done pulses during WAIT and IDLE -> no state advance and no extra oWrite.
